decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and immediate; legal values 32 and 64.
REQ-002 Parameter ALU_W, default 5, width of alu_ctrl.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  fetch offers in_instr/in_pc.
REQ-006 in_ready  out  1  stage accepts this cycle.
REQ-007 in_instr  in  32  raw RV32 instruction.
REQ-008 in_pc  in  XLEN  pc of in_instr.
REQ-009 flush  in  1  kill held and incoming instruction.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  execute accepts the bundle.
REQ-012 out_pc  out  XLEN  registered pc.
REQ-013 out_rd/out_rs1/out_rs2  out  5 each  register indices.
REQ-014 out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode, 0 for R).
REQ-015 out_alu_ctrl  out  ALU_W  ALU op code.
REQ-016 out_flags  out  11  {illegal, mem_ren, mem_wen, wb_sel, reg_wb, alu_src, auipc, branch, jump, pc_src, m_op} MSB to LSB.
REQ-017 out_func3  out  3  instr[14:12].

Function
REQ-018 The stage SHALL have one output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 Accept = in_valid & in_ready; the decoded bundle SHALL appear on the outputs the cycle after accept (latency 1).
REQ-020 in_ready SHALL equal (EMPTY | out_ready) & ~hazard & ~flush.
REQ-021 hazard SHALL equal FULL & mem_ren & out_rd!=0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)); uses_rs1 is 0 for LUI/AUIPC/JAL; uses_rs2 is 1 only for R, S and B.
REQ-022 FULL with out_ready=1 and no accept SHALL go to EMPTY; this produces exactly one bubble after a load with a dependent successor.
REQ-023 While FULL and out_ready=0, every output SHALL hold stable.
REQ-024 flush SHALL force EMPTY next cycle and discard any concurrent accept; flush takes priority over hazard and handshake.
REQ-025 ALU codes: ADD 0x00, SUB 0x01, XOR 0x02, OR 0x03, AND 0x04, SLL 0x05, SRL 0x06, BEQ 0x07, BNE 0x08, SLT 0x09, SRA 0x0A, AUIPC 0x0B, BLT 0x0C, BGE 0x0D, JAL 0x0E, SLTU 0x0F, BLTU 0x10, BGEU 0x11, PASSB 0x12 (LUI), MUL..REMU 0x13..0x1A (funct3 order).
REQ-026 SRAI/SRA SHALL be selected by instr[30]=1; loads and stores SHALL use ADD with alu_src=1; JALR SHALL use ADD with jump=1 and pc_src=0; JAL SHALL use pc_src=0.
REQ-027 reg_wb SHALL be forced to 0 when rd==0 or the instruction is S/B.
REQ-028 An unknown opcode, an unsupported funct3, or a funct7 other than 0x00/0x20 (0x01 per REQ-033) SHALL set illegal=1 and clear reg_wb, mem_wen, mem_ren, branch and jump; such bundles still flow with out_valid=1.
REQ-029 A bundle in EMPTY SHALL be all-zero except pc_src=1.

Reset
REQ-030 On reset: state EMPTY, out_valid=0, all other outputs 0 except out_flags.pc_src=1; in_ready=0 during the reset cycle.
REQ-031 Reset mid-handshake SHALL discard the held bundle without asserting out_valid.

Configuration
REQ-032 Macro RV_M_EXT_EN compiles in M-extension decode.
REQ-033 With RV_M_EXT_EN: opcode 0110011 with funct7=0x01 SHALL decode to codes 0x13+funct3, m_op=1, reg_wb=1. Without it: same encoding SHALL set illegal=1, and m_op SHALL be tied to 0.

Structure
REQ-034 ALU codes, opcode constants and out_flags bit positions SHALL live in the shared riscv_defs header.
REQ-035 Immediate generation SHALL be a sub-module imm_gen (instr, XLEN-wide imm out).

Verification
REQ-036 ADDI x1,x0,5 (0x00500093) -> next cycle out_valid=1, alu_ctrl=0x00, imm=5, alu_src=1, reg_wb=1.
REQ-037 LW x2,0(x1) then ADD x3,x2,x2 back-to-back, out_ready=1 -> in_ready=0 for one cycle, exactly one out_valid=0 cycle between them.
REQ-038 out_ready=0 for 3 cycles with FULL -> outputs unchanged, in_ready=0, no instruction lost.
REQ-039 flush asserted with in_valid=1 and FULL -> next cycle out_valid=0, incoming instruction dropped.
REQ-040 MUL x5,x6,x7 (0x027302B3) -> with RV_M_EXT_EN alu_ctrl=0x13, m_op=1; without it illegal=1, reg_wb=0.
REQ-041 SRAI x1,x1,3 (0x4030D093) -> alu_ctrl=0x0A; opcode 0x7F -> illegal=1 and all write enables 0.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared RV32 decode constants: opcodes, ALU codes, out_flags bit positions.
// Also holds the small funct3-to-ALU-code helpers used by the decoder.
package riscv_defs;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [4:0] A_ADD   = 5'h00;
    localparam logic [4:0] A_SUB   = 5'h01;
    localparam logic [4:0] A_XOR   = 5'h02;
    localparam logic [4:0] A_OR    = 5'h03;
    localparam logic [4:0] A_AND   = 5'h04;
    localparam logic [4:0] A_SLL   = 5'h05;
    localparam logic [4:0] A_SRL   = 5'h06;
    localparam logic [4:0] A_BEQ   = 5'h07;
    localparam logic [4:0] A_BNE   = 5'h08;
    localparam logic [4:0] A_SLT   = 5'h09;
    localparam logic [4:0] A_SRA   = 5'h0A;
    localparam logic [4:0] A_AUIPC = 5'h0B;
    localparam logic [4:0] A_BLT   = 5'h0C;
    localparam logic [4:0] A_BGE   = 5'h0D;
    localparam logic [4:0] A_JAL   = 5'h0E;
    localparam logic [4:0] A_SLTU  = 5'h0F;
    localparam logic [4:0] A_BLTU  = 5'h10;
    localparam logic [4:0] A_BGEU  = 5'h11;
    localparam logic [4:0] A_PASSB = 5'h12;
    localparam logic [4:0] A_MUL   = 5'h13;

    localparam int NFLAGS    = 11;
    localparam int F_ILLEGAL = 10;
    localparam int F_MEM_REN = 9;
    localparam int F_MEM_WEN = 8;
    localparam int F_WB_SEL  = 7;
    localparam int F_REG_WB  = 6;
    localparam int F_ALU_SRC = 5;
    localparam int F_AUIPC   = 4;
    localparam int F_BRANCH  = 3;
    localparam int F_JUMP    = 2;
    localparam int F_PC_SRC  = 1;
    localparam int F_M_OP    = 0;

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return A_ADD;
            3'b001:  return A_SLL;
            3'b010:  return A_SLT;
            3'b011:  return A_SLTU;
            3'b100:  return A_XOR;
            3'b101:  return A_SRL;
            3'b110:  return A_OR;
            default: return A_AND;
        endcase
    endfunction

    // 010/011 have no branch meaning; caller flags them illegal
    function automatic logic [4:0] br_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return A_BEQ;
            3'b001:  return A_BNE;
            3'b100:  return A_BLT;
            3'b101:  return A_BGE;
            3'b110:  return A_BLTU;
            3'b111:  return A_BGEU;
            default: return A_ADD;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended to XLEN.
// Opcodes without an immediate (R-type, unknown) yield zero.
module imm_gen
    import riscv_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] v;

    always_comb begin
        v = '0;
        unique case (1'b1)
            (instr[6:0] == OP_LOAD),
            (instr[6:0] == OP_IMM),
            (instr[6:0] == OP_JALR):
                v = {{20{instr[31]}}, instr[31:20]};
            (instr[6:0] == OP_STORE):
                v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            (instr[6:0] == OP_BRANCH):
                v = {{19{instr[31]}}, instr[31], instr[7],
                     instr[30:25], instr[11:8], 1'b0};
            (instr[6:0] == OP_LUI),
            (instr[6:0] == OP_AUIPC):
                v = {instr[31:12], 12'b0};
            (instr[6:0] == OP_JAL):
                v = {{11{instr[31]}}, instr[31], instr[19:12],
                     instr[20], instr[30:21], 1'b0};
            default: v = '0;
        endcase
    end

    assign imm = XLEN'($signed(v));

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: one output register, valid/ready handshake, load-use stall.
// Define RV_M_EXT_EN to decode the M extension (funct7 = 0x01 on OP).
module decode_stage
    import riscv_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int ALU_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [ALU_W-1:0] out_alu_ctrl,
    output logic [10:0]      out_flags,
    output logic [2:0]       out_func3
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN-1:0]   imm;
        logic [4:0]        alu;
        logic [NFLAGS-1:0] flags;
        logic [2:0]        func3;
    } bundle_t;

    state_t  state, state_n;
    bundle_t q, q_n, dec, empty_b;
    logic [XLEN-1:0] imm;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ill, uses_rs1, uses_rs2, hazard, accept;

    imm_gen #(.XLEN(XLEN)) u_imm (
        .instr (in_instr),
        .imm   (imm)
    );

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        empty_b = '0;
        empty_b.flags[F_PC_SRC] = 1'b1;
    end

    always_comb begin
        dec = empty_b;
        dec.pc = in_pc;
        dec.rd = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.imm = imm;
        dec.func3 = f3;
        ill = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        unique case (1'b1)
            (op == OP_LUI): begin
                dec.alu = A_PASSB;
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                uses_rs1 = 1'b0;
            end
            (op == OP_AUIPC): begin
                dec.alu = A_AUIPC;
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                dec.flags[F_AUIPC] = 1'b1;
                uses_rs1 = 1'b0;
            end
            (op == OP_JAL): begin
                dec.alu = A_JAL;
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_JUMP] = 1'b1;
                dec.flags[F_PC_SRC] = 1'b0;
                uses_rs1 = 1'b0;
            end
            (op == OP_JALR): begin
                dec.alu = A_ADD;
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                dec.flags[F_JUMP] = 1'b1;
                dec.flags[F_PC_SRC] = 1'b0;
                ill = (f3 != 3'b000);
            end
            (op == OP_BRANCH): begin
                dec.alu = br_of_f3(f3);
                dec.flags[F_BRANCH] = 1'b1;
                uses_rs2 = 1'b1;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            (op == OP_LOAD): begin
                dec.alu = A_ADD;
                dec.flags[F_MEM_REN] = 1'b1;
                dec.flags[F_WB_SEL] = 1'b1;
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            (op == OP_STORE): begin
                dec.alu = A_ADD;
                dec.flags[F_MEM_WEN] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                uses_rs2 = 1'b1;
                ill = (f3[2] == 1'b1) || (f3 == 3'b011);
            end
            (op == OP_IMM): begin
                dec.alu = alu_of_f3(f3);
                dec.flags[F_REG_WB] = 1'b1;
                dec.flags[F_ALU_SRC] = 1'b1;
                if (f3 == 3'b001)
                    ill = (f7 != 7'h00);
                else if (f3 == 3'b101) begin
                    ill = (f7 != 7'h00) && (f7 != 7'h20);
                    if (in_instr[30]) dec.alu = A_SRA;
                end
            end
            (op == OP_REG): begin
                dec.flags[F_REG_WB] = 1'b1;
                uses_rs2 = 1'b1;
                if (f7 == 7'h00)
                    dec.alu = alu_of_f3(f3);
                else if (f7 == 7'h20) begin
                    dec.alu = (f3 == 3'b101) ? A_SRA : A_SUB;
                    ill = (f3 != 3'b000) && (f3 != 3'b101);
                end
`ifdef RV_M_EXT_EN
                else if (f7 == 7'h01) begin
                    dec.alu = A_MUL + {2'b00, f3};
                    dec.flags[F_M_OP] = 1'b1;
                end
`endif
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        dec.imm = (op == OP_REG) ? '0 : imm;
        if (dec.rd == 5'd0)
            dec.flags[F_REG_WB] = 1'b0;
        // illegal bundles still flow but must not change architectural state
        if (ill) begin
            dec.flags[F_ILLEGAL] = 1'b1;
            dec.flags[F_REG_WB] = 1'b0;
            dec.flags[F_MEM_WEN] = 1'b0;
            dec.flags[F_MEM_REN] = 1'b0;
            dec.flags[F_BRANCH] = 1'b0;
            dec.flags[F_JUMP] = 1'b0;
            dec.flags[F_M_OP] = 1'b0;
        end
    end

    assign hazard = (state == FULL) && q.flags[F_MEM_REN] && (q.rd != 5'd0)
                  && ((uses_rs1 && (dec.rs1 == q.rd))
                   || (uses_rs2 && (dec.rs2 == q.rd)));

    assign in_ready = ((state == EMPTY) || out_ready)
                    && !hazard && !flush && !reset;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_n = state;
        q_n = q;
        if (flush) begin
            state_n = EMPTY;
            q_n = empty_b;
        end else if (accept) begin
            state_n = FULL;
            q_n = dec;
        end else if ((state == FULL) && out_ready) begin
            state_n = EMPTY;
            q_n = empty_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            q <= empty_b;
        end else begin
            state <= state_n;
            q <= q_n;
        end
    end

    assign out_valid = (state == FULL);
    assign out_pc = q.pc;
    assign out_rd = q.rd;
    assign out_rs1 = q.rs1;
    assign out_rs2 = q.rs2;
    assign out_imm = q.imm;
    assign out_alu_ctrl = ALU_W'(q.alu);
    assign out_flags = q.flags;
    assign out_func3 = q.func3;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default XLEN=32, ALU_W=5).
// Checks track RV_M_EXT_EN when the bench is built with it defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [4:0]  out_alu_ctrl;
    logic [10:0] out_flags;
    logic [2:0]  out_func3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_imm      (out_imm),
        .out_alu_ctrl (out_alu_ctrl),
        .out_flags    (out_flags),
        .out_func3    (out_func3)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc = 32'h0;
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_flags", out_flags, 11'h002);
        chk("rst_imm", out_imm, 0);
        chk("rst_alu", out_alu_ctrl, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();

        // ADDI x1,x0,5
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc = 32'h100;
        #1 chk("addi_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", out_valid, 1);
        chk("addi_alu", out_alu_ctrl, 5'h00);
        chk("addi_imm", out_imm, 5);
        chk("addi_flags", out_flags, 11'h062);
        chk("addi_rd", out_rd, 1);
        chk("addi_pc", out_pc, 32'h100);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_flags", out_flags, 11'h002);

        // LW x2,0(x1) then dependent ADD x3,x2,x2
        in_valid = 1'b1;
        in_instr = 32'h0000A103;
        in_pc = 32'h104;
        tick();
        in_instr = 32'h002101B3;
        in_pc = 32'h108;
        #1 chk("lw_valid", out_valid, 1);
        chk("lw_flags", out_flags, 11'h2E2);
        chk("hazard_in_ready", in_ready, 0);
        tick();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_in_ready", in_ready, 1);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_rd", out_rd, 3);
        chk("add_flags", out_flags, 11'h042);
        chk("add_imm", out_imm, 0);

        // stall 3 cycles with SRAI x1,x1,3 waiting
        out_ready = 1'b0;
        in_instr = 32'h4030D093;
        in_pc = 32'h10C;
        #1 chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_rd", out_rd, 3);
            chk("stall_pc", out_pc, 32'h108);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_in_ready", in_ready, 1);
        tick();
        chk("srai_alu", out_alu_ctrl, 5'h0A);
        chk("srai_imm", out_imm, 32'h403);
        chk("srai_rd", out_rd, 1);
        chk("srai_pc", out_pc, 32'h10C);
        chk("srai_flags", out_flags, 11'h062);

        // flush while FULL with an incoming MUL
        in_instr = 32'h027302B3;
        in_pc = 32'h110;
        flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_flags", out_flags, 11'h002);
        chk("flush_rd", out_rd, 0);
        tick();
        chk("flush_dropped", out_valid, 0);

        // MUL x5,x6,x7
        in_valid = 1'b1;
        in_instr = 32'h027302B3;
        in_pc = 32'h114;
        tick();
        chk("mul_valid", out_valid, 1);
        chk("mul_rd", out_rd, 5);
`ifdef RV_M_EXT_EN
        chk("mul_alu", out_alu_ctrl, 5'h13);
        chk("mul_flags", out_flags, 11'h043);
`else
        chk("mul_flags", out_flags, 11'h402);
`endif

        // unknown opcode 0x7F
        in_instr = 32'h0000007F;
        tick();
        chk("ill_valid", out_valid, 1);
        chk("ill_flags", out_flags, 11'h402);

        // JAL x1,8
        in_instr = 32'h008000EF;
        tick();
        chk("jal_alu", out_alu_ctrl, 5'h0E);
        chk("jal_imm", out_imm, 8);
        chk("jal_flags", out_flags, 11'h044);

        // SW x2,-4(x1)
        in_instr = 32'hFE20AE23;
        tick();
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_flags", out_flags, 11'h122);
        chk("sw_func3", out_func3, 3'b010);

        // LUI x5,0x12345
        in_instr = 32'h123452B7;
        tick();
        chk("lui_alu", out_alu_ctrl, 5'h12);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_flags", out_flags, 11'h062);

        // ADDI x0,x0,0: write to x0 suppressed
        in_instr = 32'h00000013;
        tick();
        chk("nop_flags", out_flags, 11'h022);

        // reset while holding a bundle
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_flags", out_flags, 11'h002);
        reset = 1'b0;
        tick();
        chk("midrst_after", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
